// File: rtl/vip_field_receiver_16b_pkg.sv
// Shared packet-type constants, parser states, error bit indices and the nibble
// pack/unpack helpers used by both the field generator and this receiver.
package vip_pkg;

   localparam logic [3:0] PKT_DATA = 4'h0;
   localparam logic [3:0] PKT_CTRL = 4'hF;

   localparam int ERR_CTRL  = 0;
   localparam int ERR_SHORT = 1;
   localparam int ERR_LONG  = 2;
   localparam int ERR_SEQ   = 3;

   typedef enum logic [1:0] {ST_IDLE, ST_CTRL, ST_DATA, ST_SKIP} state_t;

   // A control beat carries one byte: high nibble in data[3:0], low nibble in data[11:8].
   function automatic logic [7:0] beat_to_byte(input logic [15:0] d);
      return {d[3:0], d[11:8]};
   endfunction

   function automatic logic [15:0] byte_to_beat(input logic [7:0] b);
      return {4'h0, b[3:0], 4'h0, b[7:4]};
   endfunction

endpackage

// File: rtl/vip_field_receiver_16b_if.sv
// 16-bit Avalon-ST video sink bundle; ready is the only sink-driven signal.
// No payload storage, the source sees ready held high outside reset.
interface vip_field_receiver_16b_if;
   logic [15:0] asi_in0_data;
   logic        asi_in0_valid;
   logic        asi_in0_startofpacket;
   logic        asi_in0_endofpacket;
   logic        asi_in0_ready;

   modport master (output asi_in0_data, asi_in0_valid, asi_in0_startofpacket,
                   asi_in0_endofpacket, input asi_in0_ready);
   modport slave  (input asi_in0_data, asi_in0_valid, asi_in0_startofpacket,
                   asi_in0_endofpacket, output asi_in0_ready);
endinterface

// File: rtl/vip_field_receiver_16b_ctrl_decoder.sv
// Control packet decoder: assembles width/height/nibble, range-checks on EOP and commits.
// Commit visible the cycle after the EOP beat; never stalls the stream.
module vip_ctrl_decoder
   import vip_pkg::*;
#(
   parameter int MAX_WIDTH  = 1024,
   parameter int MAX_HEIGHT = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        beat,
   input  logic        last,
   input  logic [15:0] data,
   output logic        malformed,
   output logic [15:0] frame_width,
   output logic [15:0] frame_height,
   output logic        interlaced,
   output logic        field_id,
   output logic        params_valid
);

   localparam logic [16:0] MAX_W = 17'(MAX_WIDTH);
   localparam logic [16:0] MAX_H = 17'(MAX_HEIGHT);

   logic [2:0]  cnt, cnt_nx;
   logic [15:0] w_acc, h_acc, w_nx, h_nx;
   logic [3:0]  nib_acc, nib_nx;
   logic [7:0]  b;
   logic        ok, commit;

   // Next-accumulator values include the current beat so EOP on beat 4 can commit at once.
   always_comb begin
      b      = beat_to_byte(data);
      w_nx   = w_acc;
      h_nx   = h_acc;
      nib_nx = nib_acc;
      cnt_nx = (cnt == 3'd6) ? cnt : cnt + 3'd1;
      case (cnt)
         3'd0:    w_nx[15:8] = b;
         3'd1:    w_nx[7:0]  = b;
         3'd2:    h_nx[15:8] = b;
         3'd3:    h_nx[7:0]  = b;
         3'd4:    nib_nx     = data[3:0];
         default: ;
      endcase
   end

   assign ok = (cnt_nx == 3'd5) && (w_nx != 16'd0) && ({1'b0, w_nx} <= MAX_W)
               && (h_nx != 16'd0) && ({1'b0, h_nx} <= MAX_H);
   assign commit    = beat && last && ok;
   assign malformed = beat && last && !ok;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         w_acc        <= '0;
         h_acc        <= '0;
         nib_acc      <= '0;
         frame_width  <= '0;
         frame_height <= '0;
         interlaced   <= 1'b0;
         field_id     <= 1'b0;
         params_valid <= 1'b0;
      end else begin
         if (start) begin
            cnt <= '0;
         end else if (beat) begin
            cnt     <= cnt_nx;
            w_acc   <= w_nx;
            h_acc   <= h_nx;
            nib_acc <= nib_nx;
         end
         if (commit) begin
            frame_width  <= w_nx;
            frame_height <= h_nx;
            interlaced   <= nib_nx[3];
            field_id     <= nib_nx[2];
            params_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vip_field_receiver_16b.sv
// Avalon-ST video field parser: control decode, pixel x/y walk, sticky error flags.
// Pixels one cycle after their beat; ready is high every cycle after reset (no backpressure).
module vip_field_receiver_16b
   import vip_pkg::*;
#(
   parameter int MAX_WIDTH  = 1024,
   parameter int MAX_HEIGHT = 1024,
   parameter int CW         = 11
) (
   input  logic                 clock,
   input  logic                 reset_n,
   vip_field_receiver_16b_if.slave in0,
   output logic [15:0]          pix_data,
   output logic                 pix_valid,
   output logic [CW-1:0]        pix_x,
   output logic [CW-1:0]        pix_y,
   output logic                 pix_sof,
   output logic                 pix_eol,
   output logic                 pix_eof,
   output logic [15:0]          frame_width,
   output logic [15:0]          frame_height,
   output logic                 interlaced,
   output logic                 field_id,
   output logic                 params_valid,
   output logic [15:0]          field_count,
   output logic [3:0]           err_status,
   input  logic                 err_clear
);

   state_t      state;
   logic        ready;
   logic [15:0] x, y;
   logic        done;
   logic        xfer, sop, payload, eop, ctrl_start, ctrl_beat, ctrl_bad;
   logic        eol_hit, eof_hit, emit;
   logic [3:0]  hdr_type, err_set;

   assign in0.asi_in0_ready = ready;
   assign xfer       = in0.asi_in0_valid && ready;
   assign eop        = in0.asi_in0_endofpacket;
   assign sop        = xfer && in0.asi_in0_startofpacket;
   assign payload    = xfer && !in0.asi_in0_startofpacket;
   assign hdr_type   = in0.asi_in0_data[3:0];
   assign ctrl_start = sop && (hdr_type == PKT_CTRL) && !eop;
   assign ctrl_beat  = payload && (state == ST_CTRL);
   assign eol_hit    = (x == frame_width - 16'd1);
   assign eof_hit    = eol_hit && (y == frame_height - 16'd1);
   assign emit       = payload && (state == ST_DATA) && !done;

   vip_ctrl_decoder #(.MAX_WIDTH(MAX_WIDTH), .MAX_HEIGHT(MAX_HEIGHT)) u_dec (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (ctrl_start),
      .beat         (ctrl_beat),
      .last         (eop),
      .data         (in0.asi_in0_data),
      .malformed    (ctrl_bad),
      .frame_width  (frame_width),
      .frame_height (frame_height),
      .interlaced   (interlaced),
      .field_id     (field_id),
      .params_valid (params_valid)
   );

   always_comb begin
      err_set = '0;
      if (sop) begin
         if (state != ST_IDLE) err_set[ERR_SEQ] = 1'b1;
         if (hdr_type == PKT_CTRL && eop) err_set[ERR_CTRL] = 1'b1;
         if (hdr_type == PKT_DATA && !params_valid) err_set[ERR_SEQ] = 1'b1;
         if (hdr_type == PKT_DATA && params_valid && eop) err_set[ERR_SHORT] = 1'b1;
      end else if (payload && state == ST_DATA) begin
         if (done) err_set[ERR_LONG] = 1'b1;
         if (eop && !done && !eof_hit) err_set[ERR_SHORT] = 1'b1;
      end
      err_set[ERR_CTRL] = err_set[ERR_CTRL] | ctrl_bad;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         ready       <= 1'b0;
         x           <= '0;
         y           <= '0;
         done        <= 1'b0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_sof     <= 1'b0;
         pix_eol     <= 1'b0;
         pix_eof     <= 1'b0;
         field_count <= '0;
         err_status  <= '0;
      end else begin
         ready      <= 1'b1;
         pix_valid  <= emit;
         err_status <= (err_clear ? 4'b0000 : err_status) | err_set;
         if (emit) begin
            pix_data <= in0.asi_in0_data;
            pix_x    <= x[CW-1:0];
            pix_y    <= y[CW-1:0];
            pix_sof  <= (x == 16'd0) && (y == 16'd0);
            pix_eol  <= eol_hit;
            pix_eof  <= eof_hit;
            if (eof_hit) done <= 1'b1;
            if (eol_hit) begin
               x <= '0;
               y <= y + 16'd1;
            end else begin
               x <= x + 16'd1;
            end
         end
         // Any SOP restarts parsing, abandoning whatever packet was in flight.
         if (sop) begin
            x    <= '0;
            y    <= '0;
            done <= 1'b0;
            if (eop) begin
               state <= ST_IDLE;
               if (hdr_type == PKT_DATA && params_valid) field_count <= field_count + 16'd1;
            end else if (hdr_type == PKT_CTRL) begin
               state <= ST_CTRL;
            end else if (hdr_type == PKT_DATA && params_valid) begin
               state <= ST_DATA;
            end else begin
               state <= ST_SKIP;
            end
         end else if (payload && eop) begin
            state <= ST_IDLE;
            if (state == ST_DATA) field_count <= field_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_vip_field_receiver_16b.sv
// Directed + randomized bench for vip_field_receiver_16b with a packet-level reference model.
module tb_vip_field_receiver_16b;

   typedef struct packed {
      logic [15:0] d;
      logic [10:0] x;
      logic [10:0] y;
      logic        sof;
      logic        eol;
      logic        eof;
   } pix_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        err_clear;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic [10:0] pix_x, pix_y;
   logic        pix_sof, pix_eol, pix_eof;
   logic [15:0] frame_width, frame_height;
   logic        interlaced, field_id, params_valid;
   logic [15:0] field_count;
   logic [3:0]  err_status;

   vip_field_receiver_16b_if bus ();

   vip_field_receiver_16b #(.MAX_WIDTH(1024), .MAX_HEIGHT(1024), .CW(11)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .in0          (bus),
      .pix_data     (pix_data),
      .pix_valid    (pix_valid),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_sof      (pix_sof),
      .pix_eol      (pix_eol),
      .pix_eof      (pix_eof),
      .frame_width  (frame_width),
      .frame_height (frame_height),
      .interlaced   (interlaced),
      .field_id     (field_id),
      .params_valid (params_valid),
      .field_count  (field_count),
      .err_status   (err_status),
      .err_clear    (err_clear)
   );

   always #5 clock = ~clock;

   int          n_pass = 0;
   int          n_total = 0;
   bit          gaps = 1'b0;
   pix_t        got[$];
   logic [15:0] sent[$];

   // Reference model state: what the receiver should be holding right now.
   int          exp_w = 0, exp_h = 0, exp_fc = 0;
   bit          exp_il = 1'b0, exp_fid = 1'b0, exp_pv = 1'b0;
   logic [3:0]  exp_err = 4'b0000;

   always @(negedge clock)
      if (pix_valid === 1'b1)
         got.push_back(pix_t'{pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [15:0] d, input logic s, input logic e);
      @(negedge clock);
      if (gaps && $urandom_range(0, 3) == 0) begin
         bus.asi_in0_valid = 1'b0;
         bus.asi_in0_data = 16'($urandom);
         bus.asi_in0_startofpacket = 1'($urandom_range(0, 1));
         bus.asi_in0_endofpacket = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      bus.asi_in0_valid = 1'b1;
      bus.asi_in0_data = d;
      bus.asi_in0_startofpacket = s;
      bus.asi_in0_endofpacket = e;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         bus.asi_in0_valid = 1'b0;
         bus.asi_in0_startofpacket = 1'b0;
         bus.asi_in0_endofpacket = 1'b0;
      end
   endtask

   function automatic logic [15:0] enc(input logic [7:0] b);
      logic [15:0] r;
      r = 16'h0000;
      r[11:8] = b[3:0];
      r[3:0]  = b[7:4];
      return r;
   endfunction

   task automatic check_params(input string tag);
      chk({tag, "_width"}, frame_width, 16'(exp_w));
      chk({tag, "_height"}, frame_height, 16'(exp_h));
      chk({tag, "_ilace"}, {interlaced, field_id, params_valid}, {exp_il, exp_fid, exp_pv});
   endtask

   task automatic send_ctrl(input int w, input int h, input logic [3:0] nib, input int npay, input bit mid);
      logic [15:0] pay[5];
      pay[0] = enc(8'(w >> 8));
      pay[1] = enc(8'(w));
      pay[2] = enc(8'(h >> 8));
      pay[3] = enc(8'(h));
      pay[4] = {12'h000, nib};
      beat(16'h000F, 1'b1, 1'b0);
      for (int i = 0; i < npay; i++) beat(pay[i], 1'b0, i == npay - 1);
      idle(2);
      if (mid) exp_err[3] = 1'b1;
      if (npay == 5 && w > 0 && w <= 1024 && h > 0 && h <= 1024) begin
         exp_w = w; exp_h = h; exp_il = nib[3]; exp_fid = nib[2]; exp_pv = 1'b1;
      end else begin
         exp_err[0] = 1'b1;
      end
      chk("ctrl_err", err_status, exp_err);
      check_params("ctrl");
   endtask

   task automatic send_data(input int n, input bit with_eop);
      int          tot, exp_n;
      pix_t        e, g;
      logic [15:0] d;
      got.delete();
      sent.delete();
      beat(16'h0000, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         d = 16'($urandom);
         sent.push_back(d);
         beat(d, 1'b0, with_eop && i == n - 1);
      end
      idle(2);
      tot = exp_w * exp_h;
      exp_n = (n < tot) ? n : tot;
      chk("pix_count", 64'(got.size()), 64'(exp_n));
      for (int i = 0; i < exp_n; i++) begin
         e.d   = sent[i];
         e.x   = 11'(i % exp_w);
         e.y   = 11'(i / exp_w);
         e.sof = (i == 0);
         e.eol = ((i % exp_w) == exp_w - 1);
         e.eof = (i == tot - 1);
         g = (i < got.size()) ? got[i] : '0;
         chk("pixel", 64'(g), 64'(e));
      end
      if (with_eop) begin
         exp_fc++;
         if (n < tot) exp_err[1] = 1'b1;
         if (n > tot) exp_err[2] = 1'b1;
         chk("data_err", err_status, exp_err);
         chk("field_count", field_count, 16'(exp_fc));
      end
   endtask

   task automatic clear_err();
      @(negedge clock);
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
      exp_err = 4'b0000;
      chk("err_clear", err_status, exp_err);
   endtask

   initial begin
      int w, h, tot, n;
      reset_n = 1'b0;
      err_clear = 1'b0;
      bus.asi_in0_valid = 1'b0;
      bus.asi_in0_data = 16'h0000;
      bus.asi_in0_startofpacket = 1'b0;
      bus.asi_in0_endofpacket = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_ready", bus.asi_in0_ready, 1'b0);
      chk("rst_pix", {pix_valid, pix_sof, pix_eol, pix_eof, pix_data, pix_x, pix_y}, '0);
      chk("rst_status", {params_valid, field_count, err_status}, '0);
      check_params("rst");
      reset_n = 1'b1;
      @(negedge clock);
      chk("ready_after_rst", bus.asi_in0_ready, 1'b1);

      // Data before any control, a second SOP mid-packet, then reset while still mid-packet.
      got.delete();
      beat(16'h0000, 1'b1, 1'b0);
      beat(16'h1234, 1'b0, 1'b0);
      beat(16'h5678, 1'b0, 1'b0);
      beat(16'h0000, 1'b1, 1'b0);
      beat(16'h9ABC, 1'b0, 1'b0);
      @(negedge clock);
      chk("err_no_params", err_status, 4'b1000);
      chk("no_pixels", 64'(got.size()), 64'd0);
      chk("no_count", field_count, 16'd0);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      bus.asi_in0_valid = 1'b0;
      @(negedge clock);
      chk("midrst_ready", bus.asi_in0_ready, 1'b0);
      chk("midrst_status", {params_valid, field_count, err_status, pix_valid}, '0);
      reset_n = 1'b1;
      idle(2);

      // Literal 720x288 interlaced control, data SOP on the very next cycle, 1000 pixels then EOP.
      beat(16'h000F, 1'b1, 1'b0);
      beat(16'h0200, 1'b0, 1'b0);
      beat(16'h000D, 1'b0, 1'b0);
      beat(16'h0100, 1'b0, 1'b0);
      beat(16'h0002, 1'b0, 1'b0);
      beat(16'h000B, 1'b0, 1'b1);
      exp_w = 720; exp_h = 288; exp_il = 1'b1; exp_fid = 1'b0; exp_pv = 1'b1;
      send_data(1000, 1'b1);
      chk("plan_width", frame_width, 16'd720);
      chk("plan_height", frame_height, 16'd288);
      chk("plan_flags", {interlaced, field_id, params_valid}, 3'b101);
      chk("short_err", err_status[1], 1'b1);
      clear_err();

      // Randomized frames with idle gaps: exact, 5 beats long, or short.
      gaps = 1'b1;
      for (int r = 0; r < 9; r++) begin
         w = $urandom_range(1, 24);
         h = $urandom_range(1, 6);
         send_ctrl(w, h, 4'($urandom_range(0, 15)), 5, 1'b0);
         tot = w * h;
         case (r % 3)
            0:       n = tot;
            1:       n = tot + 5;
            default: n = (tot > 1) ? $urandom_range(1, tot - 1) : tot + 2;
         endcase
         send_data(n, 1'b1);
         clear_err();
      end

      // Malformed control packets leave previous parameters intact.
      send_ctrl(50, 10, 4'h4, 4, 1'b0);
      send_ctrl(0, 10, 4'h4, 5, 1'b0);
      send_ctrl(1025, 10, 4'h4, 5, 1'b0);
      send_ctrl(30, 1025, 4'h4, 5, 1'b0);
      send_ctrl(30, 10, 4'h4, 5, 1'b0);
      chk("bad_ctrl_sticky", err_status, 4'b0001);
      clear_err();

      // Control SOP abandons a data packet in flight; the next field uses the new size.
      gaps = 1'b0;
      send_data(3, 1'b0);
      send_ctrl(16, 4, 4'hC, 5, 1'b1);
      chk("abandon_err", err_status, 4'b1000);
      chk("abandon_count", field_count, 16'(exp_fc));
      clear_err();
      send_data(64, 1'b1);
      chk("exact_clean", err_status, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
